// File: rtl/signed_operand_entry.sv
// Signed operand entry: two-flop synchronizers, per-button debounce and a small
// entry FSM that captures operands a then b from the switches on confirm presses.
module signed_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 20000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       btn_confirm,
  input  logic       btn_clear,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       operands_valid,
  output logic       load_pulse,
  output logic [1:0] state_led
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    READY   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is confirm, index 1 is clear.
  logic [1:0]       w_btnRaw;
  logic [1:0]       w_press;
  logic [2:0]       r_swMeta;
  logic [2:0]       r_swSync;
  logic [1:0]       r_btnMeta;
  logic [1:0]       r_btnSync;
  logic [1:0]       r_stable;
  logic [1:0]       r_prev;
  logic [CNT_W-1:0] r_cnt [2];

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic       r_valid;
  logic       r_load;
  logic [2:0] w_nextA;
  logic [2:0] w_nextB;
  logic       w_nextValid;
  logic       w_nextLoad;

  assign w_btnRaw = {btn_clear, btn_confirm};
  assign w_press  = r_stable & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swMeta  <= '0;
      r_swSync  <= '0;
      r_btnMeta <= '0;
      r_btnSync <= '0;
      r_stable  <= '0;
      r_prev    <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_swMeta  <= sw;
      r_swSync  <= r_swMeta;
      r_btnMeta <= w_btnRaw;
      r_btnSync <= r_btnMeta;
      r_prev    <= r_stable;
      // A level is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles.
      for (int i = 0; i < 2; i++) begin
        if (r_btnSync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_btnSync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_a     <= w_nextA;
      r_b     <= w_nextB;
      r_valid <= w_nextValid;
      r_load  <= w_nextLoad;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextA     = r_a;
    w_nextB     = r_b;
    w_nextValid = r_valid;
    w_nextLoad  = 1'b0;
    case (r_state)
      ENTER_A: begin
        if (w_press[0]) begin
          w_nextA     = r_swSync;
          w_nextState = ENTER_B;
        end
      end
      ENTER_B: begin
        if (w_press[0]) begin
          w_nextB     = r_swSync;
          w_nextValid = 1'b1;
          w_nextLoad  = 1'b1;
          w_nextState = READY;
        end
      end
      READY: begin
        if (w_press[0]) begin
          w_nextA     = r_swSync;
          w_nextValid = 1'b0;
          w_nextState = ENTER_B;
        end
      end
      default: begin
        w_nextA     = '0;
        w_nextB     = '0;
        w_nextValid = 1'b0;
        w_nextState = ENTER_A;
      end
    endcase
    // Clear overrides any confirm arriving in the same cycle.
    if (w_press[1]) begin
      w_nextA     = '0;
      w_nextB     = '0;
      w_nextValid = 1'b0;
      w_nextLoad  = 1'b0;
      w_nextState = ENTER_A;
    end
  end

  assign a              = r_a;
  assign b              = r_b;
  assign operands_valid = r_valid;
  assign load_pulse     = r_load;
  assign state_led      = r_state;

endmodule

// File: doc/signed_operand_entry.md
Name: signed_operand_entry

Overview:
- Input-side counterpart to the signed-sum display path: captures two 3-bit two's-complement operands, a and b, from board switches.
- The user enters the operands one at a time with a confirm push-button; a clear button restarts entry.
- Button inputs are synchronized and debounced. Captured operands are held stable on registered outputs, with a valid flag, for the downstream adder/display logic.

Parameters:
- DEBOUNCE_CYCLES, 20000000, consecutive clock cycles a synchronized button level must hold before it is accepted (board: 200 ms at 100 MHz; bench overrides to 4).
- CNT_W, 25, width of debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  3  raw operand switches, two's complement (-4..+3)
- btn_confirm  input  1  raw confirm button, active-high, bouncy
- btn_clear  input  1  raw clear button, active-high, bouncy
- a  output  3  captured operand a
- b  output  3  captured operand b
- operands_valid  output  1  high while a and b both hold confirmed values
- load_pulse  output  1  one-cycle pulse when b is captured
- state_led  output  2  current entry state, for LEDs

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-low (rst_n). Every register clears immediately when rst_n is low.
- Reset values: a=0, b=0, operands_valid=0, load_pulse=0, state_led=2'b00. Synchronizers, debounce counters, stable levels and edge-detect history are all 0.
- Synchronization: sw, btn_confirm and btn_clear each pass through a 2-flop synchronizer. Operand capture always uses the synchronized sw value, never the raw value.
- Debounce, per button:
  - If sync == stable, the counter resets to 0.
  - If sync != stable and the counter == DEBOUNCE_CYCLES-1, then stable <= sync and the counter resets to 0.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Press event: combinational stable & ~stable_prev, where stable_prev is a register. It lasts exactly one cycle per accepted rising level. Release produces no event.
- Latency: count the first edge that samples raw high as edge 0. Stable rises after edge 1+DEBOUNCE_CYCLES. The FSM and outputs update at edge 2+DEBOUNCE_CYCLES.
- FSM states and state_led encoding: ENTER_A=2'b00, ENTER_B=2'b01, READY=2'b10. 2'b11 is illegal and recovers to ENTER_A with the clear-state output values.
- ENTER_A + confirm: a <= sw_sync; next state ENTER_B.
- ENTER_B + confirm: b <= sw_sync; operands_valid <= 1; load_pulse <= 1 for one cycle; next state READY.
- READY + confirm: starts a new pair. a <= sw_sync; b is held; operands_valid <= 0; next state ENTER_B.
- Clear event in any state: a <= 0, b <= 0, operands_valid <= 0, next state ENTER_A.
- Clear vs confirm in the same cycle: clear wins and the confirm is discarded.
- No event: all outputs hold. load_pulse is 0 in every cycle except the capture cycle.
- Holding a button: produces exactly one event regardless of hold duration.
- Switch changes: changes after a capture do not alter a or b.
- Reset mid-debounce or mid-entry: returns to the reset values. A button still held high when rst_n releases produces an event after the debounce latency (stable starts at 0).
- Values are stored as raw 3-bit two's complement. No sign conversion is done here; the magnitude/flag split is downstream.

Test Plan (DEBOUNCE_CYCLES=4):
- Basic entry: reset, then sw=3'b011, confirm held 10 cycles; then sw=3'b110, confirm held 10 cycles -> a=3'b011, b=3'b110, operands_valid=1, state_led=2'b10, load_pulse high exactly 1 cycle. The first capture lands exactly 6 edges after the raw rise.
- Bounce rejection: confirm toggled high 2 cycles, low 1, high 3, low -> no event, a=0, state_led=2'b00. A following 6-cycle hold gives one event.
- Re-entry from READY: with a=3, b=-2 valid, set sw=3'b100 and press confirm -> a=3'b100, b=3'b110 held, operands_valid=0, state_led=2'b01.
- Clear priority: in ENTER_B, confirm and clear rise together, both held 8 cycles -> state_led=2'b00, a=0, b=0, no load_pulse.
- Async reset mid-op: assert rst_n low between clock edges while in READY -> outputs are 0 before the next edge. Releasing rst_n with confirm held high -> a captures sw 6 edges after release.
- Hold and switch change: confirm held 100 cycles while sw changes after capture -> single capture of the value present at the event cycle; later sw changes are ignored.
